pixel_mixer_palette: RTL and testbench

- Downstream of the two tile layers and the sprite engine.
- Each pixel slot it picks the winning pixel by transparency and priority, forms a 9-bit palette index, and looks it up in on-chip palette RAM.
- Emits registered 5:5:5 RGB with blanking applied.
- Also owns the CPU-side palette read/write port.

---
 rtl/mixer_pkg.sv | 14 +
 rtl/palette_channel_ram.sv | 30 +++
 rtl/pixel_mixer_palette.sv | 155 +++++++++++++++
 tb/tb_pixel_mixer_palette.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared types and constants for the pixel mixer / palette block.
//   layer_sel_t : which layer won the pixel slot
//   CH_R/G/B    : CPU address channel codes (A[11:10])
//   OPEN_BUS    : value returned for unmapped CPU reads
package mixer_pkg;

  typedef enum logic [1:0] {SEL_B, SEL_A, SEL_OBJ} layer_sel_t;

  localparam logic [1:0]  CH_R     = 2'd0;
  localparam logic [1:0]  CH_G     = 2'd1;
  localparam logic [1:0]  CH_B     = 2'd2;
  localparam logic [15:0] OPEN_BUS = 16'hFFFF;

endpackage

// File: rtl/palette_channel_ram.sv
// One colour channel of palette RAM: true dual-port, synchronous read on both ports.
//   clk                         : clock
//   cpu_we/cpu_re/cpu_addr      : CPU port write/read strobes and entry index
//   cpu_wdata/cpu_rdata         : CPU port data; cpu_rdata holds until next read
//   pix_en/pix_addr/pix_rdata   : pixel lookup port; pix_rdata holds while pix_en = 0
// Contents are not reset. A same-cycle write and read of one entry returns old data.
module palette_channel_ram #(
  parameter int AW = 9,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          pix_en,
  input  logic [AW-1:0] pix_addr,
  output logic [DW-1:0] pix_rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_addr] <= cpu_wdata;
    if (cpu_re) cpu_rdata     <= mem[cpu_addr];
    if (pix_en) pix_rdata     <= mem[pix_addr];
  end

endmodule

// File: rtl/pixel_mixer_palette.sv
// Pixel mixer: picks the winning layer per pixel slot, looks the 9-bit index up in
// palette RAM and emits registered RGB with blanking. Also serves the CPU palette port.
//   CLK_32M, RESET_N (async low), CE_PIX (one pulse per pixel)
//   A_*/B_*/OBJ_*  : layer A, layer B and sprite pixel inputs
//   HBLANK/VBLANK  : blanks aligned with pixel inputs; HB_OUT/VB_OUT aligned with RGB
//   DIN/DOUT/A/PAL_CS/WR/RD/BYTE_SEL : CPU palette access (A[11:10] channel, A[9:1] entry)
//   R/G/B          : 5:5:5 colour out, 3 CE_PIX after the inputs
module pixel_mixer_palette
  import mixer_pkg::*;
#(
  parameter int PAL_AW = 9,
  parameter int CW     = 5
) (
  input  logic          CLK_32M,
  input  logic          RESET_N,
  input  logic          CE_PIX,
  input  logic [3:0]    A_BIT,
  input  logic [3:0]    A_COL,
  input  logic          A_PRI,
  input  logic [3:0]    B_BIT,
  input  logic [3:0]    B_COL,
  input  logic [3:0]    OBJ_BIT,
  input  logic [3:0]    OBJ_COL,
  input  logic          HBLANK,
  input  logic          VBLANK,
  input  logic [15:0]   DIN,
  output logic [15:0]   DOUT,
  input  logic [11:1]   A,
  input  logic          PAL_CS,
  input  logic          WR,
  input  logic          RD,
  input  logic [1:0]    BYTE_SEL,
  output logic [CW-1:0] R,
  output logic [CW-1:0] G,
  output logic [CW-1:0] B,
  output logic          HB_OUT,
  output logic          VB_OUT
);

  localparam int NCH = 3;

  // ---------------- stage 1: layer select ----------------
  layer_sel_t        sel;
  logic [PAL_AW-1:0] idx_d, idx_s1;
  logic              hb_s1, vb_s1, hb_s2, vb_s2;
  // vld_pipe[0]: stage 1 holds a post-reset pixel, vld_pipe[1]: stage 2 does.
  // Invalid slots are emitted as blanked so stale RAM data never leaks out.
  logic [1:0]        vld_pipe;

  always_comb begin
    sel = SEL_B;
    if (A_PRI && A_BIT != 4'd0) sel = SEL_A;
    else if (OBJ_BIT != 4'd0)   sel = SEL_OBJ;
    else if (A_BIT != 4'd0)     sel = SEL_A;
    unique case (sel)
      SEL_OBJ: idx_d = {1'b0, OBJ_COL, OBJ_BIT};
      SEL_A:   idx_d = {1'b1, A_COL, A_BIT};
      default: idx_d = {1'b1, B_COL, B_BIT};
    endcase
  end

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      idx_s1   <= '0;
      hb_s1    <= 1'b0;
      vb_s1    <= 1'b0;
      hb_s2    <= 1'b0;
      vb_s2    <= 1'b0;
      vld_pipe <= '0;
    end else if (CE_PIX) begin
      idx_s1   <= idx_d;
      hb_s1    <= HBLANK;
      vb_s1    <= VBLANK;
      hb_s2    <= hb_s1;
      vb_s2    <= vb_s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end

  // ---------------- stage 2: palette lookup ----------------
  logic [1:0]                  ch;
  logic                        cpu_wr, cpu_rd;
  logic [NCH-1:0][CW-1:0]      cpu_rdata, pix_rdata;

  assign ch     = A[11:10];
  assign cpu_wr = PAL_CS & WR & BYTE_SEL[0];
  assign cpu_rd = PAL_CS & RD;

  for (genvar ci = 0; ci < NCH; ci++) begin : g_ch
    palette_channel_ram #(.AW(PAL_AW), .DW(CW)) u_ram (
      .clk       (CLK_32M),
      .cpu_we    (cpu_wr && ch == 2'(ci)),
      .cpu_re    (cpu_rd),
      .cpu_addr  (A[PAL_AW:1]),
      .cpu_wdata (DIN[CW-1:0]),
      .cpu_rdata (cpu_rdata[ci]),
      .pix_en    (CE_PIX),
      .pix_addr  (idx_s1),
      .pix_rdata (pix_rdata[ci])
    );
  end

  // ---------------- stage 3: blank + output ----------------
  logic blank;
  assign blank = hb_s2 | vb_s2 | ~vld_pipe[1];

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      R      <= '0;
      G      <= '0;
      B      <= '0;
      HB_OUT <= 1'b1;
      VB_OUT <= 1'b1;
    end else if (CE_PIX) begin
      R      <= blank ? '0 : pix_rdata[0];
      G      <= blank ? '0 : pix_rdata[1];
      B      <= blank ? '0 : pix_rdata[2];
      HB_OUT <= hb_s2 | ~vld_pipe[1];
      VB_OUT <= vb_s2 | ~vld_pipe[1];
    end
  end

  // ---------------- CPU read-back ----------------
  // RAM read registers already hold the data one clock after RD; only the channel
  // of that read and a "has read since reset" flag need registering here.
  logic [1:0] ch_q;
  logic       rd_done;

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      ch_q    <= '0;
      rd_done <= 1'b0;
    end else if (cpu_rd) begin
      ch_q    <= ch;
      rd_done <= 1'b1;
    end
  end

  always_comb begin
    DOUT = '0;
    if (rd_done) begin
      unique case (ch_q)
        CH_R:    DOUT = {{(16-CW){1'b1}}, cpu_rdata[0]};
        CH_G:    DOUT = {{(16-CW){1'b1}}, cpu_rdata[1]};
        CH_B:    DOUT = {{(16-CW){1'b1}}, cpu_rdata[2]};
        default: DOUT = OPEN_BUS;
      endcase
    end
  end

  // upper data bits and the high byte lane have no storage behind them
  logic unused_cpu;
  assign unused_cpu = ^{DIN[15:CW], BYTE_SEL[1]};

endmodule

// File: tb/tb_pixel_mixer_palette.sv
// Directed self-checking bench for pixel_mixer_palette.
module tb_pixel_mixer_palette;

  logic        CLK_32M = 1'b0;
  logic        RESET_N, CE_PIX;
  logic [3:0]  A_BIT, A_COL, B_BIT, B_COL, OBJ_BIT, OBJ_COL;
  logic        A_PRI, HBLANK, VBLANK;
  logic [15:0] DIN, DOUT;
  logic [11:1] A;
  logic        PAL_CS, WR, RD;
  logic [1:0]  BYTE_SEL;
  logic [4:0]  R, G, B;
  logic        HB_OUT, VB_OUT;

  int checks = 0;
  int errors = 0;

  pixel_mixer_palette dut (
    .CLK_32M(CLK_32M), .RESET_N(RESET_N), .CE_PIX(CE_PIX),
    .A_BIT(A_BIT), .A_COL(A_COL), .A_PRI(A_PRI),
    .B_BIT(B_BIT), .B_COL(B_COL), .OBJ_BIT(OBJ_BIT), .OBJ_COL(OBJ_COL),
    .HBLANK(HBLANK), .VBLANK(VBLANK),
    .DIN(DIN), .DOUT(DOUT), .A(A), .PAL_CS(PAL_CS), .WR(WR), .RD(RD),
    .BYTE_SEL(BYTE_SEL),
    .R(R), .G(G), .B(B), .HB_OUT(HB_OUT), .VB_OUT(VB_OUT)
  );

  always #5 CLK_32M = ~CLK_32M;

  // inputs change and outputs are sampled 1 ns after each rising edge
  task automatic tick();
    @(posedge CLK_32M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_px(input string tag, input logic [4:0] r, input logic [4:0] g,
                        input logic [4:0] b, input logic hb, input logic vb);
    chk(tag, {R, G, B, HB_OUT, VB_OUT}, {r, g, b, hb, vb});
  endtask

  task automatic cpu_wr(input logic [1:0] ch, input logic [8:0] idx,
                        input logic [4:0] d, input logic [1:0] bs, input logic rd);
    A = {ch, idx}; DIN = {11'h5A3, d}; BYTE_SEL = bs;
    PAL_CS = 1'b1; WR = 1'b1; RD = rd;
    tick();
    PAL_CS = 1'b0; WR = 1'b0; RD = 1'b0; BYTE_SEL = 2'b00;
  endtask

  task automatic cpu_rd(input logic [1:0] ch, input logic [8:0] idx);
    A = {ch, idx}; PAL_CS = 1'b1; RD = 1'b1;
    tick();
    PAL_CS = 1'b0; RD = 1'b0;
  endtask

  task automatic set_px(input logic [3:0] abit, input logic [3:0] acol, input logic apri,
                        input logic [3:0] bbit, input logic [3:0] bcol,
                        input logic [3:0] obit, input logic [3:0] ocol,
                        input logic hb, input logic vb);
    A_BIT = abit; A_COL = acol; A_PRI = apri; B_BIT = bbit; B_COL = bcol;
    OBJ_BIT = obit; OBJ_COL = ocol; HBLANK = hb; VBLANK = vb;
  endtask

  task automatic ce();
    CE_PIX = 1'b1;
    tick();
    CE_PIX = 1'b0;
  endtask

  // pixel patterns: 0x023 (obj wins), 0x175 (A over obj), 0x190 (B fallback)
  task automatic px_023(input logic hb, input logic vb);
    set_px(4'd5, 4'd7, 1'b0, 4'd2, 4'd4, 4'd3, 4'd2, hb, vb);
  endtask
  task automatic px_175();
    set_px(4'd5, 4'd7, 1'b1, 4'd2, 4'd4, 4'd3, 4'd2, 1'b0, 1'b0);
  endtask
  task automatic px_190();
    set_px(4'd0, 4'd7, 1'b1, 4'd0, 4'd9, 4'd0, 4'd2, 1'b0, 1'b0);
  endtask

  initial begin
    RESET_N = 1'b0; CE_PIX = 1'b0; DIN = '0; A = '0;
    PAL_CS = 1'b0; WR = 1'b0; RD = 1'b0; BYTE_SEL = 2'b00;
    px_023(1'b0, 1'b0);

    // reset held with CE toggling
    for (int i = 0; i < 6; i++) begin CE_PIX = ~CE_PIX; tick(); end
    CE_PIX = 1'b0;
    chk_px("reset_px", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    chk("reset_dout", {1'b0, DOUT}, 17'h00000);
    RESET_N = 1'b1;
    tick();

    // CPU write / readback
    cpu_wr(2'd0, 9'h155, 5'h1A, 2'b01, 1'b0);
    cpu_wr(2'd1, 9'h155, 5'h05, 2'b11, 1'b0);
    cpu_wr(2'd2, 9'h155, 5'h1F, 2'b01, 1'b0);
    cpu_rd(2'd0, 9'h155); chk("rd_r", {1'b0, DOUT}, {1'b0, 16'hFFFA});
    cpu_rd(2'd1, 9'h155); chk("rd_g", {1'b0, DOUT}, {1'b0, 16'hFFE5});
    cpu_rd(2'd2, 9'h155); chk("rd_b", {1'b0, DOUT}, {1'b0, 16'hFFFF});
    cpu_rd(2'd3, 9'h155); chk("rd_ch3", {1'b0, DOUT}, {1'b0, 16'hFFFF});
    cpu_wr(2'd0, 9'h155, 5'h03, 2'b10, 1'b0);
    tick(); tick();
    chk("dout_hold", {1'b0, DOUT}, {1'b0, 16'hFFFF});
    cpu_rd(2'd0, 9'h155); chk("bytesel_hi_nowr", {1'b0, DOUT}, {1'b0, 16'hFFFA});
    cpu_wr(2'd0, 9'h155, 5'h07, 2'b01, 1'b1);
    chk("rdwr_old", {1'b0, DOUT}, {1'b0, 16'hFFFA});
    cpu_rd(2'd0, 9'h155); chk("rdwr_new", {1'b0, DOUT}, {1'b0, 16'hFFE7});

    // palette contents for pixel tests
    cpu_wr(2'd0, 9'h023, 5'h01, 2'b01, 1'b0);
    cpu_wr(2'd1, 9'h023, 5'h02, 2'b01, 1'b0);
    cpu_wr(2'd2, 9'h023, 5'h03, 2'b01, 1'b0);
    cpu_wr(2'd0, 9'h175, 5'h04, 2'b01, 1'b0);
    cpu_wr(2'd1, 9'h175, 5'h05, 2'b01, 1'b0);
    cpu_wr(2'd2, 9'h175, 5'h06, 2'b01, 1'b0);
    cpu_wr(2'd0, 9'h190, 5'h07, 2'b01, 1'b0);
    cpu_wr(2'd1, 9'h190, 5'h08, 2'b01, 1'b0);
    cpu_wr(2'd2, 9'h190, 5'h09, 2'b01, 1'b0);
    cpu_wr(2'd0, 9'h110, 5'h03, 2'b01, 1'b0);

    // priority / transparency / blanking stream, CE every cycle
    px_023(1'b0, 1'b0); ce(); chk_px("pipe_fill1", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    px_175();           ce(); chk_px("pipe_fill2", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    px_190();           ce(); chk_px("prio_obj",   5'h01, 5'h02, 5'h03, 1'b0, 1'b0);
    px_023(1'b1, 1'b0); ce(); chk_px("prio_a_pri", 5'h04, 5'h05, 5'h06, 1'b0, 1'b0);
    px_023(1'b0, 1'b1); ce(); chk_px("transp_b",   5'h07, 5'h08, 5'h09, 1'b0, 1'b0);
    px_023(1'b0, 1'b0); ce(); chk_px("hblank",     5'h00, 5'h00, 5'h00, 1'b1, 1'b0);
    ce();                     chk_px("vblank",     5'h00, 5'h00, 5'h00, 1'b0, 1'b1);
    ce();                     chk_px("unblank",    5'h01, 5'h02, 5'h03, 1'b0, 1'b0);

    // stall: single 0x190 pixel, CE every 4th cycle
    px_190(); CE_PIX = 1'b1; tick(); CE_PIX = 1'b0; px_023(1'b0, 1'b0);
    tick(); tick(); tick();
    chk_px("stall_ce1", 5'h01, 5'h02, 5'h03, 1'b0, 1'b0);
    ce(); tick(); tick();
    chk_px("stall_ce2_hold", 5'h01, 5'h02, 5'h03, 1'b0, 1'b0);
    tick();
    ce(); chk_px("stall_ce3", 5'h07, 5'h08, 5'h09, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk_px("stall_ce3_hold", 5'h07, 5'h08, 5'h09, 1'b0, 1'b0);
    ce(); chk_px("stall_ce4", 5'h01, 5'h02, 5'h03, 1'b0, 1'b0);

    // write/read collision on entry 0x110 (layer B, col 1, bit 0)
    set_px(4'd0, 4'd0, 1'b0, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
    ce();
    CE_PIX = 1'b1;
    cpu_wr(2'd0, 9'h110, 5'h11, 2'b01, 1'b0);
    CE_PIX = 1'b0;
    ce(); chk("collide_old", {12'h0, R}, {12'h0, 5'h03});
    ce(); chk("collide_new", {12'h0, R}, {12'h0, 5'h11});

    // reset mid-frame, then 3-CE refill
    px_175(); ce(); ce(); ce();
    chk_px("pre_reset", 5'h04, 5'h05, 5'h06, 1'b0, 1'b0);
    RESET_N = 1'b0;
    for (int i = 0; i < 4; i++) begin CE_PIX = ~CE_PIX; tick(); end
    CE_PIX = 1'b0;
    chk_px("mid_reset", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    chk("mid_reset_dout", {1'b0, DOUT}, 17'h00000);
    RESET_N = 1'b1; tick();
    ce(); chk_px("rel_ce1", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    ce(); chk_px("rel_ce2", 5'h00, 5'h00, 5'h00, 1'b1, 1'b1);
    ce(); chk_px("rel_ce3", 5'h04, 5'h05, 5'h06, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
